// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data arbiter for one single-ported memory; optional fetch starvation guard via MEM_PORT_ARB_STARVE_GUARD_EN
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  insnReq,
    input  logic [ADDR_WIDTH-1:0] insnAddr,
    output logic                  insnRdy,
    output logic [DATA_WIDTH-1:0] insnData,
    input  logic                  dataReq,
    input  logic                  dataWrEnable,
    input  logic [ADDR_WIDTH-1:0] dataAddr,
    input  logic [DATA_WIDTH-1:0] dataWData,
    output logic                  dataRdy,
    output logic [DATA_WIDTH-1:0] dataRData,
    output logic                  memReq,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memWData,
    input  logic                  memAck,
    input  logic [DATA_WIDTH-1:0] memRData,
    output logic                  stallIF,
    output logic                  stallMEM
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
    state_t                state_q;
    logic                  mem_req_q, mem_we_q, insn_rdy_q, data_rdy_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q, insn_data_q, data_rdata_q;
    logic                  fetch_wins;
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] starve_q, starve_d;
    assign fetch_wins = insnReq & (~dataReq | (starve_q == CW'(STARVE_LIMIT)));
    // count data grants that overtook a waiting fetch; a fetch grant clears it
    always_comb
        starve_d = (state_q != IDLE) ? starve_q :
                   fetch_wins ? '0 :
                   (dataReq & insnReq & (starve_q != CW'(STARVE_LIMIT))) ? starve_q + 1'b1 : starve_q;
    // starvation counter register
    always_ff @(posedge clk or negedge rst)
        if (!rst) starve_q <= '0;
        else      starve_q <= starve_d;
`else
    logic unused_starve;
    assign fetch_wins    = insnReq & ~dataReq;
    assign unused_starve = ^STARVE_LIMIT;
`endif
    // grant FSM: arbitrate in IDLE, hold the latched access through BUSY, pulse ready in RESP
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            insn_rdy_q   <= 1'b0;
            data_rdy_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            insn_data_q  <= '0;
            data_rdata_q <= '0;
        end else begin
            unique case (state_q)
                IDLE:
                    if (fetch_wins) begin
                        state_q    <= BUSY_I;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= insnAddr;
                    end else if (dataReq) begin
                        state_q     <= BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= dataWrEnable;
                        mem_addr_q  <= dataAddr;
                        mem_wdata_q <= dataWData;
                    end
                BUSY_I:
                    if (memAck) begin
                        state_q     <= RESP;
                        mem_req_q   <= 1'b0;
                        insn_data_q <= memRData;
                        insn_rdy_q  <= 1'b1;
                    end
                BUSY_D:
                    if (memAck) begin
                        state_q      <= RESP;
                        mem_req_q    <= 1'b0;
                        data_rdata_q <= mem_we_q ? data_rdata_q : memRData;
                        data_rdy_q   <= 1'b1;
                    end
                RESP: begin
                    state_q    <= IDLE;
                    insn_rdy_q <= 1'b0;
                    data_rdy_q <= 1'b0;
                end
            endcase
        end
    assign insnRdy   = insn_rdy_q;
    assign insnData  = insn_data_q;
    assign dataRdy   = data_rdy_q;
    assign dataRData = data_rdata_q;
    assign memReq    = mem_req_q;
    assign memWe     = mem_we_q;
    assign memAddr   = mem_addr_q;
    assign memWData  = mem_wdata_q;
    assign stallIF   = rst & insnReq & ~insn_rdy_q;
    assign stallMEM  = rst & dataReq & ~data_rdy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        insnReq = 1'b0, dataReq = 1'b0, dataWrEnable = 1'b0, memAck = 1'b0;
    logic [31:0] insnAddr = '0, dataAddr = '0, dataWData = '0, memRData = '0;
    logic        insnRdy, dataRdy, memReq, memWe, stallIF, stallMEM;
    logic [31:0] insnData, dataRData, memAddr, memWData;
    int          checks = 0, errors = 0, cyc = 0, d_cyc = 0;
    logic        exp_fetch;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .insnReq(insnReq), .insnAddr(insnAddr), .insnRdy(insnRdy), .insnData(insnData),
        .dataReq(dataReq), .dataWrEnable(dataWrEnable), .dataAddr(dataAddr), .dataWData(dataWData),
        .dataRdy(dataRdy), .dataRData(dataRData),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memAck(memAck), .memRData(memRData),
        .stallIF(stallIF), .stallMEM(stallMEM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        insnReq = 1'b1;
        #12;
        check("rst_memReq", memReq, 0);
        check("rst_memWe", memWe, 0);
        check("rst_rdy", {insnRdy, dataRdy}, 0);
        check("rst_memAddr", memAddr, 0);
        check("rst_stallIF", stallIF, 0);
        insnReq = 1'b0;
        rst = 1'b1;
        tick();

        // single fetch, 1-cycle memory
        insnReq = 1'b1; insnAddr = 32'h40; #1;
        check("f_stall_n", stallIF, 1);
        tick();
        check("f_memReq", memReq, 1);
        check("f_memAddr", memAddr, 32'h40);
        check("f_memWe", memWe, 0);
        check("f_stall_n1", stallIF, 1);
        check("f_rdy_early", insnRdy, 0);
        memAck = 1'b1; memRData = 32'h8C220004;
        tick();
        check("f_insnRdy", insnRdy, 1);
        check("f_insnData", insnData, 32'h8C220004);
        check("f_memReq_drop", memReq, 0);
        check("f_dataRdy", dataRdy, 0);
        check("f_stall_resp", stallIF, 0);
        memAck = 1'b0; insnReq = 1'b0;
        tick();
        check("f_rdy_pulse", insnRdy, 0);

        // simultaneous load and fetch: data wins, fetch follows 3 cycles later
        dataReq = 1'b1; dataWrEnable = 1'b0; dataAddr = 32'h200;
        insnReq = 1'b1; insnAddr = 32'h44;
        tick();
        check("s_memAddr_d", memAddr, 32'h200);
        memAck = 1'b1; memRData = 32'h11;
        tick();
        check("s_dataRdy", dataRdy, 1);
        check("s_insnRdy0", insnRdy, 0);
        check("s_dataRData", dataRData, 32'h11);
        d_cyc = cyc;
        memAck = 1'b0; dataReq = 1'b0; #1;
        check("s_stallMEM", stallMEM, 0);
        tick();
        check("s_idle_memReq", memReq, 0);
        check("s_idle_rdy", {insnRdy, dataRdy}, 0);
        tick();
        check("s_memAddr_i", memAddr, 32'h44);
        check("s_memWe_i", memWe, 0);
        memAck = 1'b1; memRData = 32'h22;
        tick();
        check("s_insnRdy", insnRdy, 1);
        check("s_insnData", insnData, 32'h22);
        check("s_gap", cyc - d_cyc, 3);
        check("s_dataRData_hold", dataRData, 32'h11);
        memAck = 1'b0; insnReq = 1'b0;
        tick();

        // store with 3-cycle memory, address change mid-BUSY
        dataReq = 1'b1; dataWrEnable = 1'b1; dataAddr = 32'h100; dataWData = 32'hDEADBEEF;
        tick();
        check("w_memReq1", memReq, 1);
        check("w_memWe", memWe, 1);
        check("w_memWData", memWData, 32'hDEADBEEF);
        check("w_memAddr1", memAddr, 32'h100);
        dataAddr = 32'h104; dataWData = 32'h0; dataWrEnable = 1'b0;
        tick();
        check("w_memReq2", memReq, 1);
        check("w_memAddr2", memAddr, 32'h100);
        check("w_memWData2", memWData, 32'hDEADBEEF);
        check("w_stallMEM", stallMEM, 1);
        tick();
        check("w_memReq3", memReq, 1);
        check("w_memAddr3", memAddr, 32'h100);
        memAck = 1'b1; memRData = 32'h5555AAAA;
        tick();
        check("w_dataRdy", dataRdy, 1);
        check("w_memReq_drop", memReq, 0);
        check("w_dataRData", dataRData, 32'h11);
        memAck = 1'b0; dataReq = 1'b0;
        tick();

        // starvation: fetch held high, data re-requested every IDLE
        insnReq = 1'b1; insnAddr = 32'h80;
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_PORT_ARB_STARVE_GUARD_EN
            exp_fetch = (i == 4);
`else
            exp_fetch = 1'b0;
`endif
            dataReq = 1'b1; dataWrEnable = 1'b0; dataAddr = 32'h300 + 32'(4 * i);
            tick();
            check($sformatf("st_grant%0d", i), memAddr, exp_fetch ? 32'h80 : 32'h300 + 32'(4 * i));
            memAck = 1'b1; memRData = 32'h1000 + 32'(i);
            tick();
            check($sformatf("st_rdy%0d", i), {insnRdy, dataRdy}, exp_fetch ? 2'b10 : 2'b01);
            memAck = 1'b0; dataReq = 1'b0;
            tick();
        end
        insnReq = 1'b0;
        tick();

        // memAck while IDLE is ignored
        memAck = 1'b1; memRData = 32'hBAD0BAD0;
        tick();
        check("idle_ack_memReq", memReq, 0);
        check("idle_ack_rdy", {insnRdy, dataRdy}, 0);
        memAck = 1'b0;
        tick();

        // reset mid-access, then late memAck
        dataReq = 1'b1; dataWrEnable = 1'b0; dataAddr = 32'h500;
        tick();
        check("r_busy", memReq, 1);
        rst = 1'b0; #1;
        check("r_memReq", memReq, 0);
        check("r_memAddr", memAddr, 0);
        check("r_data", {insnData, dataRData}, 0);
        check("r_stallMEM", stallMEM, 0);
        dataReq = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        memAck = 1'b1; memRData = 32'h77;
        tick();
        check("r_late_memReq", memReq, 0);
        check("r_late_rdy", {insnRdy, dataRdy}, 0);
        memAck = 1'b0;
        tick();
        check("r_late_rdy2", {insnRdy, dataRdy}, 0);
        check("r_late_data", dataRData, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester (IF stage) and the data requester (MEM stage, load/store).
- Serialises accesses through a grant FSM, latches the address, write data and write enable, and handshakes with a variable-latency memory.
- Returns read data to the winning requester as a registered one-cycle ready pulse.
- Drives stall outputs consumed by the pipeline hazard logic (today's constant-false cHazard path).

Parameters:
ADDR_WIDTH, 32, width of insnAddr, dataAddr and memAddr.
DATA_WIDTH, 32, width of every data bus.
STARVE_LIMIT, 4, consecutive lost arbitrations tolerated by fetch (used only with the optional feature).

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
insnReq  in  1  fetch request, held high until insnRdy
insnAddr  in  ADDR_WIDTH  fetch address
insnRdy  out  1  one-cycle pulse: insnData valid
insnData  out  DATA_WIDTH  fetched word, registered
dataReq  in  1  data request, held high until dataRdy
dataWrEnable  in  1  1 = store, 0 = load
dataAddr  in  ADDR_WIDTH  data address
dataWData  in  DATA_WIDTH  store data
dataRdy  out  1  one-cycle pulse: access complete, dataRData valid for loads
dataRData  out  DATA_WIDTH  load data, registered
memReq  out  1  memory request, high for the whole BUSY phase
memWe  out  1  memory write enable, latched
memAddr  out  ADDR_WIDTH  memory address, latched
memWData  out  DATA_WIDTH  memory write data, latched
memAck  in  1  memory done; memRData valid in this cycle
memRData  in  DATA_WIDTH  memory read data
stallIF  out  1  = insnReq & ~insnRdy (combinational)
stallMEM  out  1  = dataReq & ~dataRdy (combinational)

Behaviour:
- Reset values (rst low, asynchronous): state IDLE.
  - memReq, memWe, insnRdy, dataRdy = 0.
  - memAddr, memWData, insnData, dataRData = 0.
  - grant owner = none; starvation counter = 0.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - Both requests high: data wins (older instruction) unless the optional guard overrides.
  - Winning request: latch address, write data and write enable into the mem* registers; record the owner.
    - Fetch wins: memWe = 0, next state BUSY_I.
    - Data wins: memWe = dataWrEnable, next state BUSY_D.
  - No request: stay in IDLE.
- BUSY_I / BUSY_D:
  - memReq = 1; mem* outputs stay stable.
  - Requester inputs are ignored; changes to them do not affect the latched values.
  - memAck = 0: stay in the current state, with no timeout.
  - memAck = 1, BUSY_I: capture memRData into insnData and go to RESP.
  - memAck = 1, BUSY_D: capture memRData into dataRData only if memWe = 0, otherwise hold dataRData. Go to RESP.
  - memReq falls in the cycle after memAck.
- RESP:
  - Exactly one of insnRdy / dataRdy is 1, for the owner; next state IDLE.
  - Requests seen during RESP are not arbitrated; the requester drops or replaces its request on the following edge.
- Latency: with a 1-cycle memory (memAck in the first BUSY cycle), the request seen in IDLE at cycle N gives rdy in cycle N+2. Back-to-back accesses complete every 3 cycles.
- memAck outside BUSY is ignored.
- Reset mid-access: the transaction is abandoned, memReq drops immediately, and no rdy pulse is issued. A late memAck after reset is ignored.
- insnRdy and dataRdy are never high in the same cycle; memReq is never high in RESP or IDLE.
- stallIF and stallMEM are 0 while rst is low.

Optional Feature:
- Macro: MEM_PORT_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter (width ceil(log2(STARVE_LIMIT+1))) increments, saturating, each time data is granted in IDLE while insnReq = 1.
  - It clears when fetch is granted.
  - When the counter equals STARVE_LIMIT and both requests are high in IDLE, fetch wins.
- Undefined: strict data priority; the counter logic is absent.

Test Plan:
- Reset: rst = 0 while in BUSY_D with memAck never asserted -> memReq = 0 immediately; state IDLE; all outputs 0; a memAck pulse 2 cycles after rst = 1 is ignored, with no rdy pulse.
- Single fetch, 1-cycle memory: insnReq = 1, insnAddr = 0x40, memRData = 0x8C220004 -> memAddr = 0x40 and memWe = 0 for one BUSY cycle; insnRdy in cycle N+2 with insnData = 0x8C220004; stallIF high for N and N+1.
- Store with 3-cycle memory: dataReq = 1, dataWrEnable = 1, dataAddr = 0x100, dataWData = 0xDEADBEEF -> memReq high for 3 cycles with memWe = 1 and memWData = 0xDEADBEEF; dataRdy pulse; dataRData unchanged.
- Simultaneous requests: load 0x200 with memRData = 0x11 and fetch 0x44 with memRData = 0x22 -> load served first (dataRData = 0x11), then fetch (insnData = 0x22); rdy pulses exactly 3 cycles apart.
- Address change in BUSY: dataAddr changes 0x100 -> 0x104 mid-BUSY -> memAddr stays 0x100 until RESP.
- Starvation, macro defined, STARVE_LIMIT = 4: insnReq held high, dataReq re-asserted every IDLE -> 4 data grants, then a fetch grant; counter returns to 0. With the macro undefined, fetch is never granted.
